hub75_row_capture: RTL

//  Panel-side end of the HUB75 link: sinks the shift/latch/blank/address stream the LED

---
 rtl/hub75_pkg.sv | 21 ++
 rtl/hub75_row_bank.sv | 32 +++
 rtl/hub75_row_capture.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 panel-side row capture.
package hub75_pkg;

  localparam int HUB75_WIDTH  = 64;
  localparam int HUB75_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    STREAM
  } cap_state_t;

  typedef struct packed {
    logic [5:0]              x;
    logic [HUB75_ADDR_W:0]   y0;
    logic [HUB75_ADDR_W:0]   y1;
    logic [2:0]              rgb0;
    logic [2:0]              rgb1;
  } hub75_pix_t;

endpackage

// File: rtl/hub75_row_bank.sv
// Ping-pong row storage: two banks of WIDTH x 6-bit pixels, one write port,
// one registered read port with read enable (holds data while not enabled).
module hub75_row_bank #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             pll_clk,
  input  logic             i_we,
  input  logic             i_wr_bank,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [5:0]       i_wr_data,
  input  logic             i_re,
  input  logic             i_rd_bank,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [5:0]       o_rd_data
);

  logic [5:0] r_mem [0:2*WIDTH-1];
  logic [5:0] r_rd_data;

  // NOTE: the array has no reset so it can map onto block RAM; every word is
  // written by a full row of shifts before a latch can make it readable.
  always_ff @(posedge pll_clk) begin
    if (i_we)
      r_mem[{i_wr_bank, i_wr_idx}] <= i_wr_data;
    if (i_re)
      r_rd_data <= r_mem[{i_rd_bank, i_rd_idx}];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hub75_row_capture.sv
// Panel-side HUB75 sink: captures shifted rows into ping-pong banks, streams each
// committed row as a valid/ready pixel stream and counts protocol violations.
module hub75_row_capture
  import hub75_pkg::*;
#(
  parameter int WIDTH  = HUB75_WIDTH,
  parameter int ADDR_W = HUB75_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              pll_clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic [2:0]        rgb0_in,
  input  logic [2:0]        rgb1_in,
  input  logic              latch_in,
  input  logic              blank_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [5:0]        pix_x,
  output logic [ADDR_W:0]   pix_y0,
  output logic [ADDR_W:0]   pix_y1,
  output logic [2:0]        pix_rgb0,
  output logic [2:0]        pix_rgb1,
  output logic              row_done,
  output logic [CNT_W-1:0]  len_err,
  output logic [CNT_W-1:0]  addr_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [6:0] ROW_LEN = 7'(WIDTH);
  localparam logic [6:0] CNT_SAT = 7'(WIDTH + 1);
  localparam logic [5:0] LAST_X  = 6'(WIDTH - 1);

  cap_state_t        r_state;
  logic [6:0]        r_shift_cnt;
  logic              r_latch_q, r_blank_q;
  logic [ADDR_W-1:0] r_addr_q;
  logic              r_wbank, r_rbank;
  logic [5:0]        r_rd_idx, r_q_idx;
  logic              r_q_valid, r_fetch_done;
  hub75_pix_t        r_pix;
  logic              r_valid, r_row_done;
  logic [CNT_W-1:0]  r_len_err, r_addr_err, r_drop_cnt;

  logic       w_latch_rise, w_blank_fall, w_we;
  logic [6:0] w_cnt_next;
  logic       w_fire, w_last_fire, w_load, w_re;
  logic [5:0] w_rd_data;

  assign w_latch_rise = latch_in & ~r_latch_q;
  assign w_blank_fall = r_blank_q & ~blank_in;
  assign w_we         = shift_en & (r_shift_cnt < ROW_LEN);
  // The latch judges the count including a shift in its own cycle.
  assign w_cnt_next   = (shift_en && r_shift_cnt != CNT_SAT) ? r_shift_cnt + 7'd1 : r_shift_cnt;

  assign w_fire      = r_valid & pix_ready;
  assign w_last_fire = w_fire & (r_pix.x == LAST_X);
  assign w_load      = r_q_valid & (~r_valid | w_fire);
  assign w_re        = (r_state == STREAM) & ~r_fetch_done & (~r_q_valid | w_load);

  hub75_row_bank #(.WIDTH(WIDTH), .IDX_W(6)) u_bank (
    .pll_clk   (pll_clk),
    .i_we      (w_we),
    .i_wr_bank (r_wbank),
    .i_wr_idx  (r_shift_cnt[5:0]),
    .i_wr_data ({rgb1_in, rgb0_in}),
    .i_re      (w_re),
    .i_rd_bank (r_rbank),
    .i_rd_idx  (r_rd_idx),
    .o_rd_data (w_rd_data)
  );

  // NOTE: all state here updates with non-blocking assignments so every branch
  // sees the pre-edge values, independent of statement order.
  always_ff @(posedge pll_clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift_cnt  <= '0;
      r_latch_q    <= 1'b0;
      r_blank_q    <= 1'b1;
      r_addr_q     <= '0;
      r_wbank      <= 1'b0;
      r_rbank      <= 1'b0;
      r_rd_idx     <= '0;
      r_q_idx      <= '0;
      r_q_valid    <= 1'b0;
      r_fetch_done <= 1'b0;
      r_pix        <= '0;
      r_valid      <= 1'b0;
      r_row_done   <= 1'b0;
      r_len_err    <= '0;
      r_addr_err   <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_latch_q  <= latch_in;
      r_blank_q  <= blank_in;
      r_addr_q   <= addr_in;
      r_row_done <= w_last_fire;
      r_shift_cnt <= w_latch_rise ? 7'd0 : w_cnt_next;

      if (w_latch_rise) begin
        if (w_cnt_next != ROW_LEN) begin
          if (~&r_len_err) r_len_err <= r_len_err + 1'b1;
        end else if (r_state != IDLE) begin
          if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + 1'b1;
        end else begin
          r_wbank <= ~r_wbank;
          r_rbank <= r_wbank;
          r_state <= ARMED;
        end
      end

      if (~blank_in && ~r_blank_q && addr_in != r_addr_q && ~&r_addr_err)
        r_addr_err <= r_addr_err + 1'b1;

      // Two-stage read pipeline: RAM output register, then the output word.
      if (w_re) begin
        r_rd_idx <= r_rd_idx + 6'd1;
        r_q_idx  <= r_rd_idx;
        if (r_rd_idx == LAST_X) r_fetch_done <= 1'b1;
      end
      r_q_valid <= w_re | (r_q_valid & ~w_load);

      if (w_load) begin
        r_valid     <= 1'b1;
        r_pix.x     <= r_q_idx;
        r_pix.rgb0  <= w_rd_data[2:0];
        r_pix.rgb1  <= w_rd_data[5:3];
      end else if (w_fire) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ARMED: if (w_blank_fall) begin
          r_state      <= STREAM;
          r_pix.y0     <= {1'b0, addr_in};
          r_pix.y1     <= {1'b1, addr_in};
          r_rd_idx     <= '0;
          r_fetch_done <= 1'b0;
        end
        STREAM: if (w_last_fire) r_state <= IDLE;
        default: ;
      endcase
    end
  end

  assign pix_valid = r_valid;
  assign pix_x     = r_pix.x;
  assign pix_y0    = r_pix.y0;
  assign pix_y1    = r_pix.y1;
  assign pix_rgb0  = r_pix.rgb0;
  assign pix_rgb1  = r_pix.rgb1;
  assign row_done  = r_row_done;
  assign len_err   = r_len_err;
  assign addr_err  = r_addr_err;
  assign drop_cnt  = r_drop_cnt;

endmodule
